// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the four-master bus arbiter: owner encoding,
// active-low level names, default hold timeout, scan and grant-decode helpers.
package bus_arbiter_pkg;

  localparam int unsigned BUS_MASTER_CH       = 4;
  localparam int unsigned BUS_TIMEOUT_DEFAULT = 256;
  localparam int unsigned HOLD_CNT_W          = 16;

  typedef logic [1:0] BusOwnerBus;

  localparam BusOwnerBus BUS_OWNER_MASTER_0 = 2'd0;
  localparam BusOwnerBus BUS_OWNER_MASTER_1 = 2'd1;
  localparam BusOwnerBus BUS_OWNER_MASTER_2 = 2'd2;
  localparam BusOwnerBus BUS_OWNER_MASTER_3 = 2'd3;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // First active requester at owner+1, owner+2, owner+3 (mod 4); owner if none.
  function automatic BusOwnerBus scan_next(input BusOwnerBus cur,
                                           input logic [BUS_MASTER_CH-1:0] req);
    BusOwnerBus idx;
    scan_next = cur;
    for (int k = BUS_MASTER_CH - 1; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (req[idx]) scan_next = idx;
    end
  endfunction

  function automatic logic [BUS_MASTER_CH-1:0] owner_onehot(input BusOwnerBus o);
    owner_onehot = 4'b0001 << o;
  endfunction

  // Active-low grant vector: only the owner's bit is low.
  function automatic logic [BUS_MASTER_CH-1:0] grant_decode(input BusOwnerBus o);
    grant_decode = ~owner_onehot(o);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the four bus masters and the arbiter.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic       m0_req_, m1_req_, m2_req_, m3_req_;
  logic       m0_grant_, m1_grant_, m2_grant_, m3_grant_;
  BusOwnerBus owner;
  logic       timeout_;

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_grant_, m1_grant_, m2_grant_, m3_grant_, owner, timeout_
  );

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_grant_, m1_grant_, m2_grant_, m3_grant_, owner, timeout_
  );
endinterface

// File: rtl/bus_arb_timer.sv
// Contended-hold counter with terminal-count detect; used by bus_arbiter only
// when BUS_ARB_TIMEOUT_EN is defined.
module bus_arb_timer
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_,
  input  logic i_contended,
  input  logic i_clear,
  output logic o_tc_c
);

  localparam logic [HOLD_CNT_W-1:0] LP_LAST = HOLD_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [HOLD_CNT_W-1:0] r_hold_cnt;

  assign o_tc_c = i_contended && (r_hold_cnt == LP_LAST);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_hold_cnt <= '0;
    end else if (i_clear || !i_contended) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= r_hold_cnt + HOLD_CNT_W'(1);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin, parking bus arbiter for four active-low masters.
// Optional forced handover on long contended holds: define BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_,
  bus_arbiter_if.slave bus
);

  logic [BUS_MASTER_CH-1:0] w_req;
  logic                     w_owner_req;
  logic                     w_others_req;
  logic                     w_force;
  logic                     w_handover;
  BusOwnerBus               w_owner_nxt;
  BusOwnerBus               r_owner;
  logic [BUS_MASTER_CH-1:0] r_grant_;

  // Out-of-range timeouts leave a marker scope in the hierarchy.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_timeout_out_of_range
    localparam int unsigned LP_BAD_TIMEOUT = TIMEOUT_CYCLES;
  end

  assign w_req        = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
  assign w_owner_req  = w_req[r_owner];
  assign w_others_req = |(w_req & ~owner_onehot(r_owner));
  assign w_handover   = (!w_owner_req && w_others_req) || w_force;
  assign w_owner_nxt  = w_handover ? scan_next(r_owner, w_req) : r_owner;

  // Grants are registered alongside owner so they never see a req_ glitch.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_owner  <= BUS_OWNER_MASTER_0;
      r_grant_ <= grant_decode(BUS_OWNER_MASTER_0);
    end else begin
      r_owner  <= w_owner_nxt;
      r_grant_ <= grant_decode(w_owner_nxt);
    end
  end

  assign bus.owner     = r_owner;
  assign bus.m0_grant_ = r_grant_[0];
  assign bus.m1_grant_ = r_grant_[1];
  assign bus.m2_grant_ = r_grant_[2];
  assign bus.m3_grant_ = r_grant_[3];

`ifdef BUS_ARB_TIMEOUT_EN
  logic w_tc_c;
  logic r_timeout_;

  bus_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk         (clk),
    .reset_      (reset_),
    .i_contended (w_owner_req && w_others_req),
    .i_clear     (w_handover),
    .o_tc_c      (w_tc_c)
  );

  assign w_force = w_tc_c;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) r_timeout_ <= DISABLE_;
    else         r_timeout_ <= w_force ? ENABLE_ : DISABLE_;
  end

  assign bus.timeout_ = r_timeout_;
`else
  assign w_force      = 1'b0;
  assign bus.timeout_ = DISABLE_;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter (builds with or without BUS_ARB_TIMEOUT_EN).
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic clk;
  logic reset_;
  int   n_checks;
  int   n_errors;

  bus_arbiter_if u_if ();

  bus_arbiter #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp_owner);
    logic [3:0] g;
    logic [3:0] exp_g;
    g     = {u_if.m3_grant_, u_if.m2_grant_, u_if.m1_grant_, u_if.m0_grant_};
    exp_g = 4'b1111;
    exp_g[exp_owner] = 1'b0;
    check_eq({tag, ".owner"}, 8'(u_if.owner), 8'(exp_owner));
    check_eq({tag, ".grant_"}, 8'(g), 8'(exp_g));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] req_n);
    {u_if.m3_req_, u_if.m2_req_, u_if.m1_req_, u_if.m0_req_} = req_n;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    step();
    step();
    reset_ = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    set_req(4'b1111);
    do_reset();

    // Reset state holds for 10 idle cycles
    check_state("reset", 2'd0);
    check_eq("reset.timeout_", 8'(u_if.timeout_), 8'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      check_state("idle", 2'd0);
      check_eq("idle.timeout_", 8'(u_if.timeout_), 8'h1);
    end

    // m0 holds while m2 requests, release hands to m2
    set_req(4'b1010);
    for (int i = 0; i < 5; i++) begin
      step();
      check_state("m0_hold", 2'd0);
    end
    set_req(4'b1011);
    step();
    check_state("to_m2", 2'd2);

    // m3 takes over from m2
    set_req(4'b0111);
    step();
    check_state("to_m3", 2'd3);

    // m3 holds while m0..m2 request, then releases: wraps to 0
    set_req(4'b0000);
    step();
    check_state("m3_hold", 2'd3);
    set_req(4'b1000);
    step();
    check_state("wrap_to_m0", 2'd0);
    set_req(4'b1001);
    step();
    check_state("to_m1", 2'd1);
    set_req(4'b1011);
    step();
    check_state("to_m2_rr", 2'd2);

    // Owner released with nobody requesting: bus parks on m2
    set_req(4'b1111);
    step();
    check_state("park_m2", 2'd2);

    // m1 gets the bus, releases, parks, then re-requests with no gap
    set_req(4'b1101);
    step();
    check_state("to_m1_b", 2'd1);
    set_req(4'b1111);
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("park_m1", 2'd1);
    end
    set_req(4'b1101);
    check_eq("rereq.m1_grant_", 8'(u_if.m1_grant_), 8'h0);
    step();
    check_state("rereq_m1", 2'd1);

    // Hold timeout: m0 holds, m1 contends from cycle 0
    set_req(4'b1111);
    do_reset();
    set_req(4'b1100);
    for (int i = 0; i < 7; i++) begin
      step();
      check_state("contend", 2'd0);
      check_eq("contend.timeout_", 8'(u_if.timeout_), 8'h1);
    end
    step();
`ifdef BUS_ARB_TIMEOUT_EN
    check_state("forced", 2'd1);
    check_eq("forced.timeout_", 8'(u_if.timeout_), 8'h0);
    step();
    check_state("after_force", 2'd1);
    check_eq("after_force.timeout_", 8'(u_if.timeout_), 8'h1);
`else
    for (int i = 0; i < 92; i++) begin
      if (i % 23 == 0) begin
        check_state("no_timeout", 2'd0);
        check_eq("no_timeout.timeout_", 8'(u_if.timeout_), 8'h1);
      end
      step();
    end
    check_state("no_timeout_end", 2'd0);
    check_eq("no_timeout_end.timeout_", 8'(u_if.timeout_), 8'h1);
`endif

    // Async reset mid-cycle while m2 owns the bus
    set_req(4'b1011);
    step();
    check_state("pre_rst_m2", 2'd2);
    #2;
    reset_ = 1'b0;
    #1;
    check_state("async_rst", 2'd0);
    check_eq("async_rst.timeout_", 8'(u_if.timeout_), 8'h1);
    set_req(4'b1111);
    step();
    reset_ = 1'b1;
    step();
    check_state("post_rst", 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
